// File: rtl/inst_fetch_queue_pkg.sv
// Shared bus widths and exception codes for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;
    localparam int EXC_CODE_BUS  = 5;

    localparam logic [INST_BUS-1:0]     ZERO_WORD = '0;
    localparam logic [EXC_CODE_BUS-1:0] EXC_NONE  = 5'h00;
    localparam logic [EXC_CODE_BUS-1:0] EXC_ADEL  = 5'h04;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int EXC_W  = EXC_CODE_BUS
);

    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic [EXC_W-1:0]  if_exccode;
    logic              if_ready;

    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [EXC_W-1:0]  id_exccode;
    logic              id_ready;

    // slave is the queue itself; master is the surrounding pipeline
    modport slave (
        input  if_valid, if_pc, if_inst, if_exccode, id_ready,
        output if_ready, id_valid, id_pc, id_inst, id_exccode
    );

    modport master (
        output if_valid, if_pc, if_inst, if_exccode, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, id_exccode
    );

endinterface

// File: rtl/ifq_storage.sv
// Fetch queue entry array: synchronous write port, combinational read port.
module ifq_storage
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INST_ADDR_BUS + INST_BUS + EXC_CODE_BUS,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and ID with flush and exception tags.
// Optional same-cycle bypass into an empty queue: define IFQ_BYPASS_EN.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int EXC_W  = EXC_CODE_BUS
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    input  logic                     flush,
    inst_fetch_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W + EXC_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty, full, bypass, push, pop, wr_en;
    logic [ENT_W-1:0] in_ent, head_ent, out_ent;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Ready looks only at occupancy, never at id_ready
    assign bus.if_ready = cpu_rst_n & ~full;
    assign in_ent       = {bus.if_pc, bus.if_inst, bus.if_exccode};

`ifdef IFQ_BYPASS_EN
    assign bypass = empty & bus.if_valid & bus.if_ready & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign bus.id_valid = ~empty | bypass;
    // A bypassed entry taken by ID the same cycle is never stored
    assign push  = bus.if_valid & bus.if_ready & ~(bypass & bus.id_ready);
    assign pop   = bus.id_valid & bus.id_ready & ~bypass;
    assign wr_en = push & ~flush;

    assign out_ent = !bus.id_valid ? '0 : (bypass ? in_ent : head_ent);
    assign {bus.id_pc, bus.id_inst, bus.id_exccode} = out_ent;
    assign count = count_q;

    ifq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_storage (
        .clk_i   (cpu_clk_50M),
        .rst_ni  (cpu_rst_n),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_ent),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_ent)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (DEPTH=4); honours IFQ_BYPASS_EN.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  exc;
    } ent_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .flush       (flush),
        .bus         (bus),
        .count       (count)
    );

    always #10 clk = ~clk;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check handshake mid-low, count after the edge
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [4:0] exc, input bit rdy, input bit fl);
        bit   exp_ifr, exp_idv, byp, push, pop;
        ent_t e;
        @(negedge clk);
        bus.if_valid   = v;
        bus.if_pc      = pc;
        bus.if_inst    = inst;
        bus.if_exccode = exc;
        bus.id_ready   = rdy;
        flush          = fl;
        #5;
        exp_ifr = (sb.size() != DEPTH);
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (sb.size() == 0) && v && !fl;
`endif
        exp_idv = (sb.size() != 0) || byp;
        check_eq("if_ready", bus.if_ready, exp_ifr);
        check_eq("id_valid", bus.id_valid, exp_idv);
        if (!exp_idv) check_eq("id_inst_idle", bus.id_inst, ZERO_WORD);
        push = v && exp_ifr;
        pop  = exp_idv && rdy;
        if (fl) begin
            sb.delete();
        end else begin
            if (push) sb.push_back('{pc: pc, inst: inst, exc: exc});
            if (pop) begin
                e = sb.pop_front();
                check_eq("id_pc", bus.id_pc, e.pc);
                check_eq("id_inst", bus.id_inst, e.inst);
                check_eq("id_exccode", bus.id_exccode, e.exc);
            end
        end
        @(posedge clk);
        #1;
        check_eq("count", count, sb.size());
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'h0, 32'h0, EXC_NONE, rdy, 1'b0);
    endtask

    initial begin
        bus.if_valid   = 1'b0;
        bus.if_pc      = '0;
        bus.if_inst    = '0;
        bus.if_exccode = '0;
        bus.id_ready   = 1'b0;

        // Reset state
        #15;
        check_eq("rst_if_ready", bus.if_ready, 1'b0);
        check_eq("rst_id_valid", bus.id_valid, 1'b0);
        check_eq("rst_count", count, 3'd0);
        check_eq("rst_id_pc", bus.id_pc, 32'h0);
        check_eq("rst_id_inst", bus.id_inst, ZERO_WORD);
        check_eq("rst_id_exc", bus.id_exccode, EXC_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        // Two pushes with ID stalled, then drain in order
        step(1'b1, 32'hBFC0_0000, 32'h2401_0001, EXC_NONE, 1'b0, 1'b0);
        step(1'b1, 32'hBFC0_0004, 32'h2402_0002, EXC_NONE, 1'b0, 1'b0);
        check_eq("head_after_2", bus.id_pc, 32'hBFC0_0000);
        idle(1'b1);
        idle(1'b1);

        // Fill: fifth push refused
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'hBFC0_0100 + 32'(i * 4), 32'h2400_0100 + 32'(i), EXC_NONE, 1'b0, 1'b0);

        // Full: push+pop in the same cycle, only the pop lands
        step(1'b1, 32'hBFC0_0200, 32'h2400_0200, EXC_NONE, 1'b1, 1'b0);
        idle(1'b1);

        // Steady push+pop at count 2 across pointer wrap
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'hBFC0_0300 + 32'(i * 4), 32'h2400_0300 + 32'(i), EXC_NONE, 1'b1, 1'b0);

        // Flush with simultaneous push and pop at count 3
        step(1'b1, 32'hBFC0_0400, 32'h2400_0400, EXC_NONE, 1'b0, 1'b0);
        step(1'b1, 32'hBFC0_0404, 32'h2400_0404, EXC_NONE, 1'b1, 1'b1);
        step(1'b1, 32'hBFC0_0380, 32'h2400_0380, EXC_NONE, 1'b0, 1'b0);
        idle(1'b1);

        // Exception-tagged entry travels unchanged
        step(1'b1, 32'h0000_0002, 32'h0000_0000, EXC_ADEL, 1'b0, 1'b0);
        idle(1'b1);

        // Push into empty queue with ID ready (same-cycle when bypass is built in)
        step(1'b1, 32'hBFC0_0010, 32'h2400_0010, EXC_NONE, 1'b1, 1'b0);
        idle(1'b1);

        // Asynchronous reset mid-operation
        step(1'b1, 32'hBFC0_0500, 32'h2400_0500, EXC_NONE, 1'b0, 1'b0);
        step(1'b1, 32'hBFC0_0504, 32'h2400_0504, EXC_NONE, 1'b0, 1'b0);
        @(negedge clk);
        bus.if_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_eq("async_rst_count", count, 3'd0);
        check_eq("async_rst_id_valid", bus.id_valid, 1'b0);
        check_eq("async_rst_if_ready", bus.if_ready, 1'b0);
        #2;
        rst_n = 1'b1;
        step(1'b1, 32'hBFC0_0600, 32'h2400_0600, EXC_NONE, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
